// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one write port, x0 reads zero.
// Build option RF_BYPASS_EN adds same-cycle write-through forwarding on rs1/rs2 (dbg is never bypassed).
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // x0 has no storage; entries 1..NREG-1 only
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] rs1_mem;
    logic [XLEN-1:0] rs2_mem;
    logic [XLEN-1:0] dbg_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (reg_write && (rd_addr == AW'(i))) begin
                    regs_q[i] <= rd_data;
                end
            end
        end
    end

    // Decode by comparison so index 0 and indices >= NREG fall through to zero
    always_comb begin
        rs1_mem = '0;
        rs2_mem = '0;
        dbg_mem = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1_addr == AW'(i)) rs1_mem = regs_q[i];
            if (rs2_addr == AW'(i)) rs2_mem = regs_q[i];
            if (dbg_addr == AW'(i)) dbg_mem = regs_q[i];
        end
    end

`ifdef RF_BYPASS_EN
    logic wr_valid;

    always_comb begin
        wr_valid = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (rd_addr == AW'(i)) wr_valid = reg_write && rst_n;
        end
    end

    assign rs1_data = (wr_valid && (rs1_addr == rd_addr)) ? rd_data : rs1_mem;
    assign rs2_data = (wr_valid && (rs2_addr == rd_addr)) ? rd_data : rs2_mem;
`else
    assign rs1_data = rs1_mem;
    assign rs2_data = rs2_mem;
`endif

    assign dbg_data = dbg_mem;

endmodule
